// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-BCD 7-segment display slice.
// Segment codes are active-low for a common-anode display: bit7=dp, bits6..0=g..a.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    typedef logic [3:0] bcd_t;

    localparam int DIGITS = 3;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_encode(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits.
// One capture cycle, 8 add-3/shift cycles, then one DONE cycle that publishes bcd.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q;
    logic [7:0]  bin_q;
    logic [11:0] acc_q;
    logic [11:0] acc_adj;
    logic [3:0]  step_q;
    logic        busy_q;
    logic        done_q;
    logic [11:0] bcd_q;

    // NOTE: acc_adj gets a full default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q  <= {acc_adj[10:0], bin_q[7]};
                    bin_q  <= {bin_q[6:0], 1'b0};
                    step_q <= step_q + 4'd1;
                    if (step_q + 4'd1 == 4'd8) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/bin_bcd_seg_scan.sv
// Converts data_bin to BCD on change and scans 3 common-anode 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bin_bcd_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_bin,
    output logic [2:0] sel,
    output logic [7:0] seg,
    output logic       busy
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [11:0]       conv_bcd;
    logic [7:0]        last_q;
    logic              force_q;
    bcd_t [DIGITS-1:0] disp_q;
    logic [CNT_W-1:0]  scan_cnt_q;
    logic [1:0]        digit_q;
    logic [2:0]        sel_q;
    logic [2:0]        sel_d;
    logic [7:0]        seg_q;
    logic [7:0]        seg_d;
    bcd_t              digit_val;

    // Changes arriving mid-conversion are picked up again once the converter is idle.
    assign conv_start = !conv_busy && ((data_bin != last_q) || force_q);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (data_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= '0;
            force_q <= 1'b1;
            disp_q  <= '0;
        end else begin
            if (conv_start) begin
                last_q  <= data_bin;
                force_q <= 1'b0;
            end
            if (conv_done) begin
                disp_q <= conv_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            digit_q    <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        sel_d     = 3'b111;
        digit_val = 4'hF;
        case (digit_q)
            2'd0:    begin sel_d = 3'b110; digit_val = disp_q[0]; end
            2'd1:    begin sel_d = 3'b101; digit_val = disp_q[1]; end
            2'd2:    begin sel_d = 3'b011; digit_val = disp_q[2]; end
            default: ;
        endcase
        seg_d = seg_encode(digit_val);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_q == 2'd2 && disp_q[2] == 4'd0) begin
            seg_d = SEG_BLANK;
        end
        if (digit_q == 2'd1 && disp_q[2] == 4'd0 && disp_q[1] == 4'd0) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    // sel and seg share one register stage so the pins never show a mismatched pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 3'b111;
            seg_q <= SEG_BLANK;
        end else begin
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel  = sel_q;
    assign seg  = seg_q;
    assign busy = conv_busy | conv_done;

endmodule

// File: tb/tb_bin_bcd_seg_scan.sv
// Self-checking bench for bin_bcd_seg_scan with SCAN_DIV=4: per-cycle model compare plus literal digit checks.
module tb_bin_bcd_seg_scan;

    localparam int SCAN_DIV = 4;
    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data_bin = 8'd0;
    logic [2:0] sel;
    logic [7:0] seg;
    logic       busy;

    int checks = 0;
    int failures = 0;

    bin_bcd_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_bin (data_bin),
        .sel      (sel),
        .seg      (seg),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected segment pattern for decimal value v shown in digit slot d (0=ones).
    function automatic logic [7:0] exp_seg_for(input int v, input int d);
        int digit;
        digit = (d == 0) ? v % 10 : (d == 1) ? (v / 10) % 10 : v / 100;
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 2 && v < 100) return 8'hFF;
        if (d == 1 && v < 10) return 8'hFF;
`endif
        return SEG_TAB[digit];
    endfunction

    // Transaction-level model: a conversion may start every 10 edges, shows its value 10 edges later.
    int k, m_last, m_disp, m_conv, m_done_at, m_next_start, m_busy_until, m_digit;
    bit m_force, m_pending;
    logic [2:0] e_sel;
    logic [7:0] e_seg;
    logic       e_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0; m_last = 0; m_disp = 0; m_conv = 0; m_done_at = 0;
            m_next_start = 0; m_busy_until = 0; m_force = 1'b1; m_pending = 1'b0;
            e_sel = 3'b111; e_seg = 8'hFF; e_busy = 1'b0;
        end else begin
            k++;
            m_digit = ((k - 1) / SCAN_DIV) % 3;
            e_sel = ~(3'b001 << m_digit);
            e_seg = exp_seg_for(m_disp, m_digit);
            if (m_pending && k == m_done_at) begin
                m_disp = m_conv;
                m_pending = 1'b0;
            end
            if (k >= m_next_start && (int'(data_bin) != m_last || m_force)) begin
                m_last = int'(data_bin);
                m_conv = int'(data_bin);
                m_force = 1'b0;
                m_pending = 1'b1;
                m_done_at = k + 10;
                m_next_start = k + 10;
                m_busy_until = k + 10;
            end
            e_busy = (k < m_busy_until);
        end
        #1;
        check("model_sel", sel, e_sel);
        check("model_seg", seg, e_seg);
        check("model_busy", busy, e_busy);
    end

    task automatic expect_digit(input string name, input logic [2:0] s, input logic [7:0] e);
        int n = 0;
        while (sel !== s && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sel !== s) check({name, "_sel_timeout"}, sel, s);
        else check(name, seg, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset and first scanned digit
        #1 rst_n = 1'b0;
        #1;
        check("reset_sel", sel, 3'b111);
        check("reset_seg", seg, 8'hFF);
        check("reset_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("first_sel", sel, 3'b110);
        check("first_seg", seg, 8'hC0);
        repeat (15) @(negedge clk);

        // 2: 255, busy width and scanned digits
        data_bin = 8'd255;
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("busy_len_255", n, 10);
        expect_digit("d255_ones", 3'b110, 8'h92);
        expect_digit("d255_tens", 3'b101, 8'h92);
        expect_digit("d255_hund", 3'b011, 8'hA4);

        // 3: change mid-conversion is re-detected afterwards
        repeat (2) @(negedge clk);
        data_bin = 8'd100;
        repeat (3) @(negedge clk);
        data_bin = 8'd42;
        repeat (30) @(negedge clk);
        expect_digit("d42_ones", 3'b110, 8'hA4);
        expect_digit("d42_tens", 3'b101, 8'h99);
        expect_digit("d42_hund", 3'b011, LZ);

        // 4: small value, leading zeros
        data_bin = 8'd7;
        repeat (14) @(negedge clk);
        expect_digit("d7_ones", 3'b110, 8'hF8);
        expect_digit("d7_tens", 3'b101, LZ);
        expect_digit("d7_hund", 3'b011, LZ);

        // 5: reset mid-SHIFT, then reconversion of current value
        data_bin = 8'd199;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sel", sel, 3'b111);
        check("midrst_seg", seg, 8'hFF);
        check("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        expect_digit("d199_hund", 3'b011, 8'hF9);
        expect_digit("d199_tens", 3'b101, 8'h90);
        expect_digit("d199_ones", 3'b110, 8'h90);

        // 6: sweep every value, model compares every cycle
        for (int v = 0; v < 256; v++) begin
            data_bin = 8'(v);
            repeat (12) @(negedge clk);
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_bcd_seg_scan.md
Name: bin_bcd_seg_scan

Overview:
- Display-side consumer of the 8-bit saturated key-count value `data_bin` (0..255).
- Converts the value to 3 BCD digits using a sequential double-dabble FSM.
- Drives a 3-digit common-anode 7-segment display by time-multiplexing the digits.
- Sits between the key-count block and the board's segment/digit-select pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- data_bin  in  8  unsigned binary value to display
- sel  out  3  digit select, active-low one-cold; sel[0]=ones, sel[1]=tens, sel[2]=hundreds
- seg  out  8  segment drive, active-low; bit7=dp, bits6..0 = g..a
- busy  out  1  high while a conversion is in progress

Behaviour:
- Reset values:
  - sel=3'b111, seg=8'hFF, busy=0.
  - Display BCD registers = 0,0,0; last-converted register = 0.
  - Scan counter = 0; digit index = 0.
  - force flag = 1, so one conversion runs after reset.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE → SHIFT when (data_bin != last-converted) or force. On this transition:
    - data_bin is captured into the shift register;
    - the BCD accumulator is cleared;
    - last-converted ← data_bin;
    - force ← 0.
  - SHIFT runs exactly 8 cycles. Each cycle:
    - add 3 to every BCD nibble ≥5;
    - then shift {bcd, bin} left by 1.
    - 4-bit step counter: leave SHIFT when the step count reaches 8.
  - DONE lasts 1 cycle: copy the accumulator into the display BCD registers, then go to IDLE.
  - busy=1 in SHIFT and DONE.
- Latency: data_bin change sampled at edge N → display registers updated at edge N+10 (1 capture + 8 shift + 1 DONE).
- Changes to data_bin while busy are ignored. They are re-detected in IDLE, so the final value is always displayed.
- Back-to-back changes: at most one conversion per 10 cycles; intermediate values may be skipped.
- Scan:
  - Counter counts 0..SCAN_DIV-1 and wraps.
  - At wrap, digit index advances 0→1→2→0.
  - sel and seg are registered together from the same digit index, so they never disagree for a cycle.
- Segment code (dp off, bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any nibble >9 (unreachable) → FF.
- The display BCD registers change only in DONE. A scan in progress sees the new value from the next registered update.
- Reset mid-conversion aborts the conversion, returns to reset values, and reconverts the current data_bin afterwards.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - hundreds digit blanks (seg=FF) when its value is 0;
  - tens digit blanks when hundreds=0 and tens=0;
  - the ones digit is never blanked (value 0 shows "  0").
- Undefined: all three digits are always shown (value 7 → "007").

Decomposition:
- Package seg_pkg:
  - FSM state enum (IDLE, SHIFT, DONE);
  - 7-seg code constants SEG_0..SEG_9 and SEG_BLANK=8'hFF;
  - DIGITS=3;
  - BCD nibble typedef.
- Sub-module bin2bcd_seq (FSM + double-dabble datapath; ports clk, rst_n, start, bin[7:0], busy, done, bcd[11:0]).
- The top holds change detection, scan counter, digit mux, encoder and blanking.

Test Plan (SCAN_DIV=4 for sim):
1. Assert rst_n low, then release → sel=111, seg=FF during reset. Within 10 cycles the display registers read 0,0,0. First scanned digit: sel=110, seg=C0.
2. data_bin=255 at edge N → busy high for cycles N+1..N+10. Display registers read 2,5,5 at N+10. Scan shows sel=110/seg=92, sel=101/seg=92, sel=011/seg=A4, each for 4 cycles.
3. data_bin 100 → 42 three cycles into the conversion → display first shows 1,0,0, then a second conversion starts and the display ends at 0,4,2.
4. data_bin=7:
   - with LEADING_ZERO_BLANK_EN, the hundreds and tens slots give seg=FF and the ones slot gives F8;
   - without it, C0, C0, F8.
5. data_bin=199, rst_n pulsed low mid-SHIFT → outputs return to reset values immediately. After release the display reaches 1,9,9 10 cycles later with no stale partial digits.
6. data_bin 0→1→2→… stepping every 12 cycles up to 255 → scoreboard checks every DONE value against data_bin/100, /10 %10, %10.
